gate_test_sequencer: RTL and testbench



---
 rtl/gate_test_pkg.sv | 29 ++
 rtl/gate_vec_rom.sv | 19 +
 rtl/gate_test_sequencer.sv | 115 +++++++++++
 tb/tb_gate_test_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate self-test sequencer.
// The table below holds the default stimulus/expected-O pairs for the 7-input gate.
package gate_test_pkg;

  localparam int DUT_W     = 7;
  localparam int ROM_DEPTH = 16;
  localparam int ROM_AW    = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Entry 0 sits in the least significant slice; unused entries are never addressed.
  localparam logic [ROM_DEPTH-1:0][DUT_W-1:0] DEF_STIM = {
    {11{7'b0000000}},
    7'b1100001,
    7'b0000110,
    7'b0000000,
    7'b0000001,
    7'b0000000
  };

  localparam logic [ROM_DEPTH-1:0] DEF_EXP = 16'b0000_0000_0001_0101;

endpackage

// File: rtl/gate_vec_rom.sv
// Combinational vector lookup: index -> {stimulus, expected O}.
// Kept separate so the table can be swapped without touching the sequencer FSM.
module gate_vec_rom
  import gate_test_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  output logic [DUT_W-1:0] stim,
  output logic             expected
);

  logic [ROM_AW-1:0] addr;

  assign addr     = ROM_AW'(idx);
  assign stim     = DEF_STIM[addr];
  assign expected = DEF_EXP[addr];

endmodule

// File: rtl/gate_test_sequencer.sv
// On-chip self-test sequencer: applies each table vector to the gate, waits a
// settle time, compares O against the expected value and tallies mismatches.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int NUM_VEC    = 5,
  parameter int SETTLE_CYC = 2,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_o,
  output logic [DUT_W-1:0] dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W-1:0] fail_count,
  output logic [IDX_W-1:0] first_fail_idx
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [IDX_W-1:0] ALL_ONES = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [DUT_W-1:0] dut_in_nxt;
  logic [IDX_W-1:0] fail_count_nxt, first_fail_nxt;
  logic [DUT_W-1:0] rom_stim;
  logic             rom_exp;

  gate_vec_rom #(.IDX_W(IDX_W)) u_rom (
    .idx      (idx),
    .stim     (rom_stim),
    .expected (rom_exp)
  );

  // start is a level sampled only in IDLE/DONE; abort wins over everything
  // and is ignored in IDLE, where there is nothing to abort.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    dut_in_nxt     = dut_in;
    fail_count_nxt = fail_count;
    first_fail_nxt = first_fail_idx;
    if (abort && state != S_IDLE) begin
      state_nxt  = S_IDLE;
      dut_in_nxt = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_nxt      = S_APPLY;
            idx_nxt        = '0;
            fail_count_nxt = '0;
            first_fail_nxt = ALL_ONES;
          end
        end
        S_APPLY: begin
          dut_in_nxt = rom_stim;
          cnt_nxt    = CNT_LOAD;
          state_nxt  = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == '0) state_nxt = S_CHECK;
          else           cnt_nxt   = cnt - 1'b1;
        end
        S_CHECK: begin
          if (dut_o != rom_exp) begin
            if (fail_count != ALL_ONES) fail_count_nxt = fail_count + 1'b1;
            if (first_fail_idx == ALL_ONES) first_fail_nxt = idx;
          end
          if (idx == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = S_APPLY;
          end
        end
        default: begin
          state_nxt  = S_IDLE;
          dut_in_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      idx            <= '0;
      cnt            <= '0;
      dut_in         <= '0;
      fail_count     <= '0;
      first_fail_idx <= ALL_ONES;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      cnt            <= cnt_nxt;
      dut_in         <= dut_in_nxt;
      fail_count     <= fail_count_nxt;
      first_fail_idx <= first_fail_nxt;
    end
  end

  assign busy = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (fail_count == '0);

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: table of full-run cases plus
// hand-written sequences for start-while-busy, abort and mid-run reset.
module tb_gate_test_sequencer;

  localparam int NUM_VEC    = 5;
  localparam int SETTLE_CYC = 2;
  localparam int IDX_W      = 4;
  localparam int RUN_EDGES  = NUM_VEC * (SETTLE_CYC + 2);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             dut_o;
  logic [6:0]       dut_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [IDX_W-1:0] fail_count;
  logic [IDX_W-1:0] first_fail_idx;

  int checks = 0;
  int errors = 0;
  int model_mode = 0; // 0: correct gate, 1: stuck-at-0, 2: stuck-at-1

  logic [6:0] stim_tab [NUM_VEC];
  logic [6:0] exp_q [$];

  typedef struct {
    string      name;
    int         mode;
    logic [3:0] exp_fail;
    logic [3:0] exp_first;
    logic       exp_pass;
  } case_t;

  case_t cases [3];

  gate_test_sequencer #(
    .NUM_VEC    (NUM_VEC),
    .SETTLE_CYC (SETTLE_CYC),
    .IDX_W      (IDX_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .dut_o          (dut_o),
    .dut_in         (dut_in),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate model consistent with the vector table: O = ~(G | (E & F)) | (A & B)
  function automatic logic gate_model(input logic [6:0] v);
    return ~(v[0] | (v[2] & v[1])) | (v[6] & v[5]);
  endfunction

  always_comb begin
    case (model_mode)
      1:       dut_o = 1'b0;
      2:       dut_o = 1'b1;
      default: dut_o = gate_model(dut_in);
    endcase
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " busy"},       32'(busy), 0);
    chk({tag, " done"},       32'(done), 0);
    chk({tag, " pass"},       32'(pass), 0);
    chk({tag, " fail_count"}, 32'(fail_count), 0);
    chk({tag, " first_fail"}, 32'(first_fail_idx), 32'hF);
    chk({tag, " dut_in"},     32'(dut_in), 0);
  endtask

  // Pulses start across one edge (E0); leaves the bench just after E0.
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs edges from_edge..to_edge relative to E0, scoring dut_in at each CHECK cycle.
  task automatic run_edges(input int from_edge, input int to_edge);
    for (int e = from_edge; e <= to_edge; e++) begin
      step();
      if ((e % (SETTLE_CYC + 2)) == SETTLE_CYC + 1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: expected queue empty at edge %0d", e);
        end else begin
          chk($sformatf("dut_in@check e%0d", e), 32'(dut_in), 32'(exp_q.pop_front()));
        end
      end
      if (e == RUN_EDGES - 1) chk("done low before last edge", 32'(done), 0);
    end
  endtask

  task automatic load_queue();
    exp_q.delete();
    for (int k = 0; k < NUM_VEC; k++) exp_q.push_back(stim_tab[k]);
  endtask

  task automatic check_results(input string tag, input logic [3:0] f,
                               input logic [3:0] first, input logic p);
    chk({tag, " done"},       32'(done), 1);
    chk({tag, " busy"},       32'(busy), 0);
    chk({tag, " pass"},       32'(pass), 32'(p));
    chk({tag, " fail_count"}, 32'(fail_count), 32'(f));
    chk({tag, " first_fail"}, 32'(first_fail_idx), 32'(first));
    chk({tag, " dut_in held"}, 32'(dut_in), 32'(stim_tab[NUM_VEC-1]));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;

    stim_tab[0] = 7'b0000000;
    stim_tab[1] = 7'b0000001;
    stim_tab[2] = 7'b0000000;
    stim_tab[3] = 7'b0000110;
    stim_tab[4] = 7'b1100001;

    cases[0] = '{"correct",   0, 4'd0, 4'hF, 1'b1};
    cases[1] = '{"stuck0",    1, 4'd3, 4'd0, 1'b0};
    cases[2] = '{"stuck1",    2, 4'd2, 4'd1, 1'b0};

    // Table-driven full runs, start sampled at cycle 5
    for (int c = 0; c < 3; c++) begin
      model_mode = cases[c].mode;
      apply_reset();
      check_reset_values({cases[c].name, " reset"});
      repeat (2) step();
      load_queue();
      pulse_start();
      chk({cases[c].name, " busy after start"}, 32'(busy), 1);
      chk({cases[c].name, " done after start"}, 32'(done), 0);
      run_edges(1, RUN_EDGES);
      check_results(cases[c].name, cases[c].exp_fail, cases[c].exp_first, cases[c].exp_pass);
    end

    // start re-pulsed during SETTLE of vector 2 is ignored
    model_mode = 2;
    apply_reset();
    load_queue();
    pulse_start();
    run_edges(1, 9);
    start = 1'b1;
    run_edges(10, 10);
    start = 1'b0;
    chk("ignored start busy", 32'(busy), 1);
    run_edges(11, RUN_EDGES);
    check_results("ignored start", 4'd2, 4'd1, 1'b0);

    // start in DONE launches a new run with results cleared on that edge
    model_mode = 0;
    load_queue();
    pulse_start();
    chk("restart busy",       32'(busy), 1);
    chk("restart done",       32'(done), 0);
    chk("restart fail_count", 32'(fail_count), 0);
    chk("restart first_fail", 32'(first_fail_idx), 32'hF);
    run_edges(1, RUN_EDGES);
    check_results("restart", 4'd0, 4'hF, 1'b1);

    // abort during CHECK of vector 3 keeps partial results
    model_mode = 2;
    apply_reset();
    load_queue();
    pulse_start();
    run_edges(1, 14);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort busy",       32'(busy), 0);
    chk("abort done",       32'(done), 0);
    chk("abort pass",       32'(pass), 0);
    chk("abort dut_in",     32'(dut_in), 0);
    chk("abort fail_count", 32'(fail_count), 1);
    chk("abort first_fail", 32'(first_fail_idx), 1);
    repeat (8) step();
    chk("abort stays idle busy",   32'(busy), 0);
    chk("abort stays idle dut_in", 32'(dut_in), 0);

    // reset for one cycle during vector 2 discards the run
    model_mode = 2;
    load_queue();
    pulse_start();
    run_edges(1, 9);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_values("midrun reset");
    repeat (25) step();
    chk("post reset quiet busy", 32'(busy), 0);
    chk("post reset quiet done", 32'(done), 0);
    chk("post reset quiet fail", 32'(fail_count), 0);
    load_queue();
    pulse_start();
    run_edges(1, RUN_EDGES);
    check_results("after reset run", 4'd2, 4'd1, 1'b0);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expected entries left unconsumed", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
